full_st0_tap_ctrl: RTL
======================

FULL_ST0_TAP_CTRL -- requirements
Module: full_st0_tap_ctrl

Interface
REQ-001 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port load_vld  in  1  serial tap-load word valid.
REQ-004 SHALL have port load_data  in  32  tap word to load.
REQ-005 SHALL have port load_ready  out  1  controller accepts a load word this cycle.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begin read sweep of all tap rows.
REQ-007 SHALL have port upd_vld  in  1  updated tap row valid.
REQ-008 SHALL have port upd_data  in  192  updated row, six 32-bit lanes, lane 0 in [31:0].
REQ-009 SHALL have port tap_rd_vld / tap_rd_address  out  1 / 2  tap-memory read strobe and row.
REQ-010 SHALL have port tap_wr_vld / tap_wr_address  out  1 / 2  full-row write strobe and row.
REQ-011 SHALL have port tap_sub_vld / tap_sub_addr / tap_sub_data  out  1 / 3 / 32  single-lane write strobe, lane, data.
REQ-012 SHALL have port tap_wr_data  out  192  full-row write data.
REQ-013 SHALL have port rd_first / rd_last  out  1 / 1  marks row 0 / row 3 read strobes.
REQ-014 SHALL have port busy, load_done, upd_done, upd_err  out  1 each  status.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, READ, UPDATE; all tap_* outputs registered (1-cycle latency from the causing input).
REQ-016 IDLE: load_vld -> LOAD (word accepted); else start -> READ; load_vld wins if both asserted.
REQ-017 load_ready SHALL be 1 in IDLE and LOAD, 0 otherwise; load_vld while load_ready=0 ignored.
REQ-018 Each accepted load word SHALL produce next cycle tap_sub_vld=1, tap_sub_addr=lane_cnt (0..5), tap_wr_address=row_cnt (0..3), tap_sub_data=load_data, tap_wr_vld=0.
REQ-019 lane_cnt SHALL increment per accepted word, wrap 5->0, incrementing row_cnt on wrap; after word 24 (row 3, lane 5) FSM -> IDLE, load_done pulses 1 cycle, counters clear.
REQ-020 LOAD with load_vld=0 SHALL hold state and counters (gaps allowed, no timeout).
REQ-021 READ: tap_rd_vld=1 for exactly 4 consecutive cycles, rows 0,1,2,3; rd_first with row 0, rd_last with row 3; then -> UPDATE.
REQ-022 UPDATE: each upd_vld SHALL produce tap_wr_vld=1, tap_wr_address=upd_cnt (0..3), tap_wr_data=upd_data, tap_sub_vld=0; after 4th row -> IDLE, upd_done pulses 1 cycle.
REQ-023 upd_vld outside UPDATE SHALL be ignored and set sticky upd_err (cleared only by reset).
REQ-024 start outside IDLE SHALL be ignored.
REQ-025 tap_sub_vld and tap_wr_vld SHALL never be 1 in the same cycle; tap_rd_vld never overlaps either.
REQ-026 busy SHALL be 1 whenever state != IDLE.

Reset
REQ-027 reset SHALL force IDLE, clear lane_cnt, row_cnt, upd_cnt, upd_err; all strobes, flags, addresses and data outputs 0.
REQ-028 reset mid-LOAD/READ/UPDATE SHALL abort with no further strobes; partial rows are not completed.

Structure
REQ-029 Lane count (6), row depth (4), lane width (32) and tap-interface struct (rd/wr/sub fields) SHALL live in the shared types package.
REQ-030 Block SHALL be one flat module; no sub-module is required.

Verification
REQ-031 Load 24 words 0x100..0x117 back-to-back -> sub strobes lane 0..5 per row 0..3, word 0x117 at row 3 lane 5, load_done 1 cycle after.
REQ-032 Load with gaps (load_vld every 3rd cycle) -> same address sequence, busy held high throughout.
REQ-033 start in IDLE -> rd_vld 4 cycles rows 0..3, rd_first/rd_last on first/last, then UPDATE; 4 upd_vld rows 0xA..A, 0xB..B, 0xC..C, 0xD..D -> wr strobes rows 0..3, upd_done.
REQ-034 load_vld and start same cycle in IDLE -> LOAD entered, no rd_vld.
REQ-035 upd_vld in IDLE -> no wr strobe, upd_err=1 and remains 1 until reset.
REQ-036 reset after 10th load word -> outputs 0 next cycle; subsequent load restarts at row 0 lane 0.

Source files
------------

// File: rtl/full_st0_tap_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// full_st0_tap_ctrl_pkg
// Shared geometry, FSM state encoding and tap-memory interface bundle for the
// stage-0 tap controller.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
package full_st0_tap_ctrl_pkg;

  localparam int unsigned TAP_LANES = 6;
  localparam int unsigned TAP_ROWS  = 4;
  localparam int unsigned LANE_W    = 32;
  localparam int unsigned ROW_W     = TAP_LANES * LANE_W;
  localparam int unsigned ROW_AW    = 2;
  localparam int unsigned LANE_AW   = 3;

  localparam logic [LANE_AW-1:0] LAST_LANE = LANE_AW'(TAP_LANES - 1);
  localparam logic [ROW_AW-1:0]  LAST_ROW  = ROW_AW'(TAP_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_READ   = 2'd2,
    ST_UPDATE = 2'd3
  } tap_state_e;

  // Everything that goes towards the tap memory, registered as one bundle.
  typedef struct packed {
    logic               rd_vld;
    logic [ROW_AW-1:0]  rd_addr;
    logic               wr_vld;
    logic [ROW_AW-1:0]  wr_addr;
    logic [ROW_W-1:0]   wr_data;
    logic               sub_vld;
    logic [LANE_AW-1:0] sub_addr;
    logic [LANE_W-1:0]  sub_data;
  } tap_if_t;

endpackage
`default_nettype wire

// File: rtl/full_st0_tap_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// full_st0_tap_ctrl
// Sequences serial tap loading (single-lane writes), a read sweep of all tap
// rows, and the following full-row write-back of updated rows.
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
module full_st0_tap_ctrl
  import full_st0_tap_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_vld,
  input  logic [LANE_W-1:0]  load_data,
  output logic               load_ready,
  input  logic               start,
  input  logic               upd_vld,
  input  logic [ROW_W-1:0]   upd_data,
  output logic               tap_rd_vld,
  output logic [ROW_AW-1:0]  tap_rd_address,
  output logic               tap_wr_vld,
  output logic [ROW_AW-1:0]  tap_wr_address,
  output logic               tap_sub_vld,
  output logic [LANE_AW-1:0] tap_sub_addr,
  output logic [LANE_W-1:0]  tap_sub_data,
  output logic [ROW_W-1:0]   tap_wr_data,
  output logic               rd_first,
  output logic               rd_last,
  output logic               busy,
  output logic               load_done,
  output logic               upd_done,
  output logic               upd_err
);

  tap_state_e         state_q, state_d;
  logic [LANE_AW-1:0] lane_cnt_q, lane_cnt_d;
  logic [ROW_AW-1:0]  row_cnt_q, row_cnt_d;
  logic [ROW_AW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [ROW_AW-1:0]  upd_cnt_q, upd_cnt_d;
  tap_if_t            tap_q, tap_d;
  logic               rd_first_q, rd_first_d;
  logic               rd_last_q, rd_last_d;
  logic               load_done_q, load_done_d;
  logic               upd_done_q, upd_done_d;
  logic               upd_err_q, upd_err_d;
  logic               load_acc;

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign load_acc   = load_ready && load_vld;

  // Next-state, counter and strobe decode; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    lane_cnt_d  = lane_cnt_q;
    row_cnt_d   = row_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    upd_cnt_d   = upd_cnt_q;
    tap_d       = '0;
    rd_first_d  = 1'b0;
    rd_last_d   = 1'b0;
    load_done_d = 1'b0;
    upd_done_d  = 1'b0;
    // Stray update rows are dropped but remembered until reset.
    upd_err_d   = upd_err_q | (upd_vld && (state_q != ST_UPDATE));

    if (load_acc) begin
      // A load word beats a simultaneous start while idle.
      tap_d.sub_vld  = 1'b1;
      tap_d.sub_addr = lane_cnt_q;
      tap_d.wr_addr  = row_cnt_q;
      tap_d.sub_data = load_data;
      if ((lane_cnt_q == LAST_LANE) && (row_cnt_q == LAST_ROW)) begin
        state_d     = ST_IDLE;
        lane_cnt_d  = '0;
        row_cnt_d   = '0;
        load_done_d = 1'b1;
      end else begin
        state_d = ST_LOAD;
        if (lane_cnt_q == LAST_LANE) begin
          lane_cnt_d = '0;
          row_cnt_d  = row_cnt_q + 1'b1;
        end else begin
          lane_cnt_d = lane_cnt_q + 1'b1;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tap_d.rd_vld  = 1'b1;
            tap_d.rd_addr = '0;
            rd_first_d    = 1'b1;
            rd_cnt_d      = ROW_AW'(1);
            state_d       = ST_READ;
          end
        end
        ST_READ: begin
          tap_d.rd_vld  = 1'b1;
          tap_d.rd_addr = rd_cnt_q;
          if (rd_cnt_q == LAST_ROW) begin
            rd_last_d = 1'b1;
            rd_cnt_d  = '0;
            state_d   = ST_UPDATE;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        ST_UPDATE: begin
          if (upd_vld) begin
            tap_d.wr_vld  = 1'b1;
            tap_d.wr_addr = upd_cnt_q;
            tap_d.wr_data = upd_data;
            if (upd_cnt_q == LAST_ROW) begin
              upd_cnt_d  = '0;
              upd_done_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              upd_cnt_d = upd_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          // ST_LOAD with no word this cycle: hold position.
        end
      endcase
    end
  end

  // State, counters and all registered outputs; reset aborts any sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lane_cnt_q  <= '0;
      row_cnt_q   <= '0;
      rd_cnt_q    <= '0;
      upd_cnt_q   <= '0;
      tap_q       <= '0;
      rd_first_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      load_done_q <= 1'b0;
      upd_done_q  <= 1'b0;
      upd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      row_cnt_q   <= row_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
      tap_q       <= tap_d;
      rd_first_q  <= rd_first_d;
      rd_last_q   <= rd_last_d;
      load_done_q <= load_done_d;
      upd_done_q  <= upd_done_d;
      upd_err_q   <= upd_err_d;
    end
  end

  assign tap_rd_vld     = tap_q.rd_vld;
  assign tap_rd_address = tap_q.rd_addr;
  assign tap_wr_vld     = tap_q.wr_vld;
  assign tap_wr_address = tap_q.wr_addr;
  assign tap_wr_data    = tap_q.wr_data;
  assign tap_sub_vld    = tap_q.sub_vld;
  assign tap_sub_addr   = tap_q.sub_addr;
  assign tap_sub_data   = tap_q.sub_data;
  assign rd_first       = rd_first_q;
  assign rd_last        = rd_last_q;
  assign load_done      = load_done_q;
  assign upd_done       = upd_done_q;
  assign upd_err        = upd_err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire
